display_arbiter: RTL and testbench

Shares the single 8-digit seven-segment display among four requesters (e.g. CPU result register, PC trace, debug probe, status word). It sits directly upstream of the 8-digit scan driver and supplies its 32-bit value. The block runs round-robin arbitration with a minimum on-screen hold time, so no source can flicker the display or starve the others. It also computes a leading-zero blanking mask for the scan driver.

---
 rtl/display_arbiter.sv | 276 +++++++++++++++++++++++++++
 tb/tb_display_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// display_arbiter: shares one 8-digit seven-segment display among four sources
// using round-robin arbitration with a minimum on-screen hold time, and builds
// the leading-zero blanking mask for the downstream scan driver.
// Latency: 1 cycle. gnt, val_out and digit_en all change on the edge after
// req/val are sampled.
// Backpressure: none. req is a level; a granted source keeps the display for
// HOLD_CYCLES cycles even if it drops req, and is preempted only by contention.
//
// Ports:
//   clk          system clock, all state on posedge
//   reset        synchronous, active-high; dominates every other input
//   req[3:0]     level-sensitive request per source
//   val0..val3   32-bit value per source (8 hex nibbles)
//   gnt[3:0]     one-hot grant, all-zero when idle
//   owner[1:0]   index of the current or most recent owner
//   active       1 while any source is granted
//   val_out      value forwarded to the scan driver
//   digit_en     per-digit enable, bit i drives val_out[4i+3:4i]
//
// Optional feature macro: DISPLAY_ARB_BLINK_EN
//   When defined, digit_en blinks between the frozen mask and 8'h00 every
//   BLINK_CYCLES cycles while idle. When undefined, no blink logic is built
//   and BLINK_CYCLES is only range-checked.

module display_arbiter #(
    parameter int unsigned HOLD_CYCLES  = 1_000_000,
    parameter int unsigned BLINK_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] val0,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic [31:0] val3,
    output logic [3:0]  gnt,
    output logic [1:0]  owner,
    output logic        active,
    output logic [31:0] val_out,
    output logic [7:0]  digit_en
);

    // Both parameters must be non-zero; reject illegal builds at elaboration.
    if (HOLD_CYCLES == 0 || BLINK_CYCLES == 0) begin : g_bad_params
        $error("display_arbiter: HOLD_CYCLES and BLINK_CYCLES must be >= 1");
    end

    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OWN  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // First set request at or after 'start', wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Leading-zero blanking: digit i is lit if it or any more significant
    // nibble is non-zero. The least significant digit is always lit so a
    // zero value still shows "0".
    function automatic logic [7:0] lz_mask(input logic [31:0] v);
        logic [7:0] m;
        logic       seen;
        m    = 8'h00;
        seen = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            seen = seen | (v[4*i +: 4] != 4'h0);
            m[i] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;    // where the next search starts
    logic [1:0]  owner_q, owner_d;
    logic [31:0] val_q, val_d;
    logic [7:0]  mask_q, mask_d;

    logic [31:0] val_arr [4];
    logic [3:0]  owner_oh;
    logic        others_req;
    logic        grant_ev;
    logic        decide;

    assign val_arr[0] = val0;
    assign val_arr[1] = val1;
    assign val_arr[2] = val2;
    assign val_arr[3] = val3;

    assign owner_oh   = 4'b0001 << owner_q;
    assign others_req = |(req & ~owner_oh);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= 32'd0;
            rr_ptr_q   <= 2'd0;
            owner_q    <= 2'd0;
            val_q      <= 32'd0;
            mask_q     <= 8'h01;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            val_q      <= val_d;
            mask_q     <= mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // The hold counter shows HOLD_LAST during the final guaranteed cycle of
    // a tenure. The owner's fate is decided at the end of that cycle (the
    // same decision OWN makes), so a contended owner is on screen for exactly
    // HOLD_CYCLES cycles. An uncontended owner that still requests settles
    // in OWN, where the counter stops and cannot wrap.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        grant_ev   = 1'b0;
        decide     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_ev = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    decide = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            ST_OWN: begin
                decide = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (decide) begin
            if (others_req) begin
                grant_ev = 1'b1;
            end else if (!req[owner_q]) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_OWN;
            end
        end

        // rr_ptr_q is owner+1 after any grant, 0 after reset, so the search
        // order is fair and the current owner is always considered last.
        if (grant_ev) begin
            owner_d    = rr_pick(req, rr_ptr_q);
            rr_ptr_d   = owner_d + 2'd1;
            hold_cnt_d = 32'd0;
            state_d    = ST_HOLD;
        end
    end

    // ------------------------------------------------------------------
    // Display datapath: track the owner's value while it requests, freeze
    // otherwise (including idle). The mask follows the same next value.
    // ------------------------------------------------------------------
    always_comb begin
        val_d  = val_q;
        mask_d = mask_q;
        if (state_d != ST_IDLE && req[owner_d]) begin
            val_d  = val_arr[owner_d];
            mask_d = lz_mask(val_arr[owner_d]);
        end
    end

`ifdef DISPLAY_ARB_BLINK_EN
    // ------------------------------------------------------------------
    // Idle blink. The phase counter runs only while the FSM stays in IDLE;
    // each entry into IDLE starts in the lit phase, so the first toggle is
    // to blank. Any grant clears it, which restores the mask on that edge.
    // ------------------------------------------------------------------
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);

    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blank_q, blank_d;

    always_comb begin
        blink_cnt_d = 32'd0;
        blank_d     = 1'b0;
        if (state_q == ST_IDLE && state_d == ST_IDLE) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 32'd0;
                blank_d     = ~blank_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 32'd1;
                blank_d     = blank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= 32'd0;
            blank_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs: pure decode of registered state, so they move only on edges.
    // ------------------------------------------------------------------
    always_comb begin
        gnt     = 4'b0000;
        active  = 1'b0;
        owner   = owner_q;
        val_out = val_q;
        if (state_q != ST_IDLE) begin
            gnt    = owner_oh;
            active = 1'b1;
        end
`ifdef DISPLAY_ARB_BLINK_EN
        digit_en = blank_q ? 8'h00 : mask_q;
`else
        digit_en = mask_q;
`endif
    end

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(gnt));

    a_gnt_owner: assert property (@(posedge clk) disable iff (reset)
        active |-> gnt[owner]);

    a_digit0_lit: assert property (@(posedge clk) disable iff (reset)
        (state_q != ST_IDLE) |-> digit_en[0]);

endmodule

// File: tb/tb_display_arbiter.sv
// Randomized + directed bench for display_arbiter against a tenure-based
// reference model (grant tenure counted in cycles, round-robin search
// computed directly from the last owner).

module tb_display_arbiter;

    localparam int HOLD  = 4;
    localparam int BLINK = 3;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] val_in [4];
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        active;
    logic [31:0] val_out;
    logic [7:0]  digit_en;

    int n_checks = 0;
    int n_errors = 0;

    display_arbiter #(
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .val0     (val_in[0]),
        .val1     (val_in[1]),
        .val2     (val_in[2]),
        .val3     (val_in[3]),
        .gnt      (gnt),
        .owner    (owner),
        .active   (active),
        .val_out  (val_out),
        .digit_en (digit_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_granted;
    int          m_owner;
    bit          m_fresh;       // no grant since reset: search from 0
    int          m_tenure;      // cycles the current owner has been shown
    logic [31:0] m_val;
    int          m_idle_edges;  // edges spent continuously idle

    function automatic int first_from(input logic [3:0] r, input int start);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (start + k) % 4;
            if (r[idx]) return idx;
        end
        return start;
    endfunction

    function automatic logic [7:0] ref_mask(input logic [31:0] v);
        int top;
        top = 0;
        for (int n = 0; n < 8; n++)
            if (((v >> (4 * n)) & 32'hF) != 32'h0) top = n;
        return 8'((1 << (top + 1)) - 1);
    endfunction

    task automatic model_step();
        bit          was;
        logic [3:0]  others;
        if (reset) begin
            m_granted    = 1'b0;
            m_owner      = 0;
            m_fresh      = 1'b1;
            m_tenure     = 0;
            m_val        = 32'h0;
            m_idle_edges = 0;
            return;
        end
        was = m_granted;
        if (!m_granted) begin
            if (req != 4'b0) begin
                m_owner   = first_from(req, m_fresh ? 0 : (m_owner + 1) % 4);
                m_granted = 1'b1;
                m_tenure  = 0;
                m_fresh   = 1'b0;
            end
        end else begin
            m_tenure++;
            if (m_tenure >= HOLD) begin
                others = req;
                others[m_owner] = 1'b0;
                if (others != 4'b0) begin
                    m_owner  = first_from(req, (m_owner + 1) % 4);
                    m_tenure = 0;
                end else if (!req[m_owner]) begin
                    m_granted = 1'b0;
                end
            end
        end
        if (m_granted && req[m_owner]) m_val = val_in[m_owner];
        if (m_granted || was) m_idle_edges = 0;
        else m_idle_edges++;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [3:0] eg;
        logic [7:0] ed;
        eg = 4'b0;
        if (m_granted) eg[m_owner] = 1'b1;
        ed = ref_mask(m_val);
`ifdef DISPLAY_ARB_BLINK_EN
        if (!m_granted && ((m_idle_edges / BLINK) % 2 == 1)) ed = 8'h00;
`endif
        check("gnt",      32'(gnt),      32'(eg));
        check("owner",    32'(owner),    32'(m_owner));
        check("active",   32'(active),   32'(m_granted));
        check("val_out",  val_out,       m_val);
        check("digit_en", 32'(digit_en), 32'(ed));
    endtask

    // Drive inputs, let one edge happen, then compare on the falling edge.
    task automatic step(input bit r, input logic [3:0] q);
        reset = r;
        req   = q;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] cur_req;
        reset = 1'b1;
        req   = 4'hF;
        for (int s = 0; s < 4; s++) val_in[s] = 32'h0;

        // Reset with every source requesting.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'hF);
            check("tp_reset_gnt",   32'(gnt),      32'h0);
            check("tp_reset_val",   val_out,       32'h0);
            check("tp_reset_digit", 32'(digit_en), 32'h01);
        end

        // Full contention from IDLE: 0,1,2,3,0 each for HOLD cycles.
        for (int n = 1; n <= 17; n++) begin
            val_in[(n - 1) % 4] = $urandom;
            step(1'b0, 4'hF);
            check("tp_rr_gnt",    32'(gnt),    32'(1 << (((n - 1) / HOLD) % 4)));
            check("tp_rr_active", 32'(active), 32'h1);
        end

        // Single requester with a blanked value.
        step(1'b1, 4'h0);
        val_in[2] = 32'h0001_2345;
        step(1'b0, 4'b0100);
        check("tp_single_gnt",   32'(gnt),      32'h4);
        check("tp_single_owner", 32'(owner),    32'h2);
        check("tp_single_val",   val_out,       32'h0001_2345);
        check("tp_single_digit", 32'(digit_en), 32'h1F);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0100);
            check("tp_single_hold", 32'(gnt), 32'h4);
        end

        // Early drop: owner 1 drops during HOLD while source 3 waits.
        step(1'b1, 4'h0);
        val_in[1] = 32'hCAFE_0001;
        val_in[3] = 32'h0000_0BAD;
        step(1'b0, 4'b0010);
        step(1'b0, 4'b1010);
        val_in[1] = 32'h1111_1111;
        step(1'b0, 4'b1000);
        check("tp_drop_gnt", 32'(gnt), 32'h2);
        check("tp_drop_val", val_out,  32'hCAFE_0001);
        step(1'b0, 4'b1000);
        check("tp_drop_gnt", 32'(gnt), 32'h2);
        step(1'b0, 4'b1000);
        check("tp_drop_switch", 32'(gnt), 32'h8);
        check("tp_drop_newval", val_out,  32'h0000_0BAD);

        // Idle freeze with the top digit set.
        step(1'b1, 4'h0);
        val_in[0] = 32'h8000_0000;
        step(1'b0, 4'b0001);
        val_in[0] = 32'h0000_1234;
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);
        check("tp_freeze_held", 32'(gnt), 32'h1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 4'b0000);
            check("tp_freeze_gnt",    32'(gnt),    32'h0);
            check("tp_freeze_active", 32'(active), 32'h0);
            check("tp_freeze_val",    val_out,     32'h8000_0000);
`ifndef DISPLAY_ARB_BLINK_EN
            check("tp_freeze_digit",  32'(digit_en), 32'hFF);
`endif
        end

        // Reset in the middle of HOLD; round-robin restarts at 0.
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0100);
        check("tp_midhold_pre", 32'(gnt), 32'h4);
        step(1'b1, 4'b0100);
        check("tp_midhold_gnt", 32'(gnt), 32'h0);
        step(1'b0, 4'hF);
        check("tp_midhold_rr", 32'(gnt), 32'h1);

        // Randomized traffic against the model.
        cur_req = 4'h0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) == 0) cur_req = 4'($urandom);
            for (int s = 0; s < 4; s++)
                if ($urandom_range(0, 3) == 0)
                    val_in[s] = $urandom >> $urandom_range(0, 31);
            step($urandom_range(0, 59) == 0, cur_req);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
